// File: rtl/mips_pkg.sv
// mips_pkg: shared op/state encodings and op-class helpers for the multiply/divide unit.
package mips_pkg;
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;
  typedef enum logic [1:0] {IDLE, COMPUTE, FIX, WRITE} mdu_state_t;
  localparam int MDU_ITERS = 32;
  function automatic logic op_is_div(mdu_op_t o);
    return o == MDU_DIV || o == MDU_DIVU;
  endfunction
  function automatic logic op_is_signed(mdu_op_t o);
    return o == MDU_MULT || o == MDU_DIV;
  endfunction
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum, rem, diff;
  logic           ge;
  assign sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, b_i};
  // Shifted remainder needs an extra bit: it can reach almost 2*|b|.
  assign rem  = acc_i[2*WIDTH-1:WIDTH-1];
  assign ge   = rem >= {1'b0, b_i};
  assign diff = rem - {1'b0, b_i};
  assign acc_o = div_i ? (ge ? {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1}
                             : {rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0})
                       : (acc_i[0] ? {sum, acc_i[WIDTH-1:1]} : {1'b0, acc_i[2*WIDTH-1:1]});
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU on magnitudes with sign fix, driving HI/LO write ports.
// MULT_DIV_FAST_MULT_EN: multiplies use one combinational multiplier in FIX and skip COMPUTE.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             HI_write_enable,
  output logic             LO_write_enable,
  output logic [WIDTH-1:0] HI_write_data,
  output logic [WIDTH-1:0] LO_write_data
);
  localparam int CW = $clog2(ITERS + 1);
  mdu_state_t         state_q, state_d;
  mdu_op_t            op_q, op_in;
  logic [WIDTH-1:0]   a_q, bm_q, hi_q, lo_q, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_q, step_acc, prod, res;
  logic [CW-1:0]      cnt_q;
  logic               nq_q, nr_q, sa, sb, is_div;
  assign op_in = mdu_op_t'(op);
  assign is_div = op_is_div(op_q);
  assign sa = op_is_signed(op_in) & operand_a[WIDTH-1];
  assign sb = op_is_signed(op_in) & operand_b[WIDTH-1];
  assign a_mag = sa ? -operand_a : operand_a;
  assign b_mag = sb ? -operand_b : operand_b;
`ifdef MULT_DIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
  assign prod = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, bm_q};
`else
  localparam bit FAST = 1'b0;
  assign prod = acc_q;
`endif
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i(acc_q),
    .b_i  (bm_q),
    .div_i(is_div),
    .acc_o(step_acc)
  );
  // Divide by zero bypasses the sign fix and reports the raw dividend.
  assign res = !is_div ? (nq_q ? -prod : prod)
             : bm_q == '0 ? {a_q, {WIDTH{1'b1}}}
             : {nr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH],
                nq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]};
  always_comb begin
    state_d = flush ? IDLE
            : state_q == IDLE ? (start ? (FAST && !op_is_div(op_in) ? FIX : COMPUTE) : IDLE)
            : state_q == COMPUTE ? (cnt_q == CW'(ITERS - 1) ? FIX : COMPUTE)
            : state_q == FIX ? WRITE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      bm_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start && !flush) begin
        op_q  <= op_in;
        a_q   <= operand_a;
        bm_q  <= b_mag;
        nq_q  <= sa ^ sb;
        nr_q  <= op_in == MDU_DIV && sa;
        acc_q <= {{WIDTH{1'b0}}, a_mag};
        cnt_q <= '0;
      end else if (state_q == COMPUTE) begin
        acc_q <= step_acc;
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == FIX) begin
        {hi_q, lo_q} <= res;
      end
    end
  end
  assign busy            = state_q != IDLE;
  assign done            = state_q == WRITE;
  assign HI_write_enable = done;
  assign LO_write_enable = done;
  assign HI_write_data   = hi_q;
  assign LO_write_data   = lo_q;
endmodule
